// File: rtl/cr2_tff_pkg.sv
// Shared types and constants for the CoolRunner-II style register bank.
// Mode encoding, per-bit priority enum and counter saturation helper.
package cr2_tff_pkg;

  localparam logic MODE_D = 1'b0;
  localparam logic MODE_T = 1'b1;

  typedef enum logic [2:0] {
    PRIO_RST,
    PRIO_CLR,
    PRIO_PRE,
    PRIO_HOLD,
    PRIO_UPD
  } prio_e;

  function automatic logic [31:0] sat_max(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/cr2_tff_cell.sv
// One macrocell register bit: priority next-state logic plus its flop.
// Reports whether the bit will change on the coming edge (never on reset).
module cr2_tff_cell
  import cr2_tff_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic mode,
  input  logic init,
  input  logic ce,
  input  logic pre,
  input  logic clr,
  input  logic t,
  output logic q,
  output logic chg
);

  prio_e prio;
  logic  q_d;
  logic  q_q;

  // Pick which rule governs this bit on the coming edge.
  always_comb begin
    prio = PRIO_UPD;
    if (!rst_n)   prio = PRIO_RST;
    else if (clr) prio = PRIO_CLR;
    else if (pre) prio = PRIO_PRE;
    else if (!ce) prio = PRIO_HOLD;
  end

  // Next-state value for the selected rule.
  always_comb begin
    q_d = q_q;
    unique case (prio)
      PRIO_RST:  q_d = init;
      PRIO_CLR:  q_d = 1'b0;
      PRIO_PRE:  q_d = 1'b1;
      PRIO_HOLD: q_d = q_q;
      PRIO_UPD:  q_d = (mode == MODE_T) ? (q_q ^ t) : t;
      default:   q_d = q_q;
    endcase
  end

  // State flop with synchronous reset to the init value.
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= init;
    else        q_q <= q_d;
  end

  assign q   = q_q;
  assign chg = (prio != PRIO_RST) & (q_d ^ q_q);

endmodule

// File: rtl/cr2_tff_bank.sv
// Bank of WIDTH macrocell registers with change flags and change counter.
// Counter is built only when CR2_TFF_BANK_CNT_EN is defined.
module cr2_tff_bank
  import cr2_tff_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] T_MASK  = '1,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter bit               CLK_POL = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             C,
  input  logic             RST_N,
  input  logic             CE,
  input  logic [WIDTH-1:0] PRE,
  input  logic [WIDTH-1:0] CLR,
  input  logic [WIDTH-1:0] T,
  input  logic             CNT_CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] CHG,
  output logic [CNT_W-1:0] CNT
);

  logic             clk;
  logic [WIDTH-1:0] chg_bit;
  logic [WIDTH-1:0] chg_d;
  logic [WIDTH-1:0] chg_q;

  assign clk = CLK_POL ? C : ~C;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    cr2_tff_cell u_cell (
      .clk   (clk),
      .rst_n (RST_N),
      .mode  (T_MASK[i]),
      .init  (INIT[i]),
      .ce    (CE),
      .pre   (PRE[i]),
      .clr   (CLR[i]),
      .t     (T[i]),
      .q     (Q[i]),
      .chg   (chg_bit[i])
    );
  end

  // Change flags follow the cells' per-bit change detection.
  always_comb chg_d = chg_bit;

  // Change-flag register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!RST_N) chg_q <= '0;
    else        chg_q <= chg_d;
  end

  assign CHG = chg_q;

`ifdef CR2_TFF_BANK_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of edges that changed any bit; clear wins.
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR)
      cnt_d = '0;
    else if ((|chg_bit) && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (!RST_N) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = CNT_CLR;
  assign CNT = '0;
`endif

endmodule

// File: tb/tb_cr2_tff_bank.sv
// Randomised and directed bench for cr2_tff_bank, both clock polarities.
// Reference model computes each bit from the priority rules directly.
module tb_cr2_tff_bank;

  localparam int         W     = 4;
  localparam logic [3:0] MASK  = 4'b0011;
  localparam logic [3:0] INITV = 4'b1010;
  localparam int         CW    = 3;

  logic       C = 1'b0;
  logic       RST_N = 1'b0;
  logic       CE = 1'b0;
  logic [3:0] PRE = '0;
  logic [3:0] CLR = '0;
  logic [3:0] T = '0;
  logic       CNT_CLR = 1'b0;

  logic [3:0]    q_p, chg_p, q_n, chg_n;
  logic [CW-1:0] cnt_p, cnt_n;

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0] m_q;
  int         m_cnt;
  bit         have_state = 0;

  always #5 C = ~C;

  cr2_tff_bank #(
    .WIDTH(W), .T_MASK(MASK), .INIT(INITV),
    .CLK_POL(1'b1), .CNT_W(CW)
  ) dut (
    .C(C), .RST_N(RST_N), .CE(CE), .PRE(PRE), .CLR(CLR),
    .T(T), .CNT_CLR(CNT_CLR), .Q(q_p), .CHG(chg_p), .CNT(cnt_p)
  );

  cr2_tff_bank #(
    .WIDTH(W), .T_MASK(MASK), .INIT(INITV),
    .CLK_POL(1'b0), .CNT_W(CW)
  ) dut_n (
    .C(C), .RST_N(RST_N), .CE(CE), .PRE(PRE), .CLR(CLR),
    .T(T), .CNT_CLR(CNT_CLR), .Q(q_n), .CHG(chg_n), .CNT(cnt_n)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // One active edge on each instance; called at posedge+1.
  task automatic step(input logic rst, input logic ce,
                      input logic [3:0] pre, input logic [3:0] clr,
                      input logic [3:0] t, input logic cclr);
    logic [3:0] nq;
    logic [3:0] nchg;
    int         ncnt;
    RST_N = rst; CE = ce; PRE = pre; CLR = clr; T = t; CNT_CLR = cclr;
    if (!rst) begin
      nq = INITV;
      nchg = '0;
      ncnt = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (clr[i])       nq[i] = 1'b0;
        else if (pre[i])  nq[i] = 1'b1;
        else if (!ce)     nq[i] = m_q[i];
        else if (MASK[i]) nq[i] = m_q[i] ^ t[i];
        else              nq[i] = t[i];
      end
      nchg = nq ^ m_q;
      if (cclr)                         ncnt = 0;
      else if (nq != m_q && m_cnt < 7)  ncnt = m_cnt + 1;
      else                              ncnt = m_cnt;
    end
`ifndef CR2_TFF_BANK_CNT_EN
    ncnt = 0;
`endif
    @(negedge C); #1;
    chk("neg_q", q_n, nq);
    chk("neg_chg", chg_n, nchg);
    chk("neg_cnt", cnt_n, ncnt);
    if (have_state) chk("pos_q_early", q_p, m_q);
    @(posedge C); #1;
    chk("pos_q", q_p, nq);
    chk("pos_chg", chg_p, nchg);
    chk("pos_cnt", cnt_p, ncnt);
    m_q = nq;
    m_cnt = ncnt;
    have_state = 1;
  endtask

  function automatic int cnt_exp(input int v);
`ifdef CR2_TFF_BANK_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  initial begin
    m_q = INITV;
    m_cnt = 0;
    @(posedge C); #1;

    step(0, 1, 4'hF, 4'h0, 4'h0, 0);
    step(0, 1, 4'hF, 4'h0, 4'h0, 0);
    chk("rst_q", q_p, 4'b1010);
    chk("rst_chg", chg_p, 4'b0000);
    chk("rst_cnt", cnt_p, 0);

    step(1, 1, 4'h0, 4'h0, 4'b0101, 0);
    chk("mix_q", q_p, 4'b0111);
    chk("mix_chg", chg_p, 4'b1101);
    chk("mix_cnt", cnt_p, cnt_exp(1));

    step(1, 0, 4'b1100, 4'b0110, 4'h0, 0);
    chk("prio_q", q_p, 4'b1001);
    step(1, 0, 4'h0, 4'h0, 4'hF, 0);
    chk("prio_hold_chg", chg_p, 4'b0000);
    chk("prio_hold_q", q_p, 4'b1001);

    for (int k = 0; k < 5; k++) step(1, 0, 4'h0, 4'h0, 4'hF, 0);
    chk("ce_hold_q", q_p, 4'b1001);
    step(1, 1, 4'h0, 4'h0, 4'hF, 0);
    chk("ce_go_q", q_p, 4'b1110);

    for (int k = 0; k < 10; k++) step(1, 1, 4'h0, 4'h0, 4'b0011, 0);
    chk("sat_cnt", cnt_p, cnt_exp(7));
    step(1, 1, 4'h0, 4'h0, 4'b0011, 1);
    chk("cclr_cnt", cnt_p, 0);

    for (int k = 0; k < 300; k++) begin
      logic r;
      r = ($urandom_range(0, 19) != 0);
      step(r, ($urandom_range(0, 3) != 0),
           4'($urandom & $urandom & 32'hF),
           4'($urandom & $urandom & 32'hF),
           4'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
